// File: rtl/riscv_rf_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// riscv_rf_wb_arbiter_pkg
//   Shared types for the register-file write-back path.
//   - dift_tag_t  : DIFT taint tag carried alongside every write
//   - rf_wb_req_t : result-bus write request shared by EX, LSU and APU
//   - wb_src_e    : source selected for a register-file write port
// ----------------------------------------------------------------------------
package riscv_rf_wb_arbiter_pkg;

    localparam int unsigned DIFT_TAG_WIDTH = 2;
    localparam int unsigned RF_ADDR_WIDTH  = 6;
    localparam int unsigned RF_DATA_WIDTH  = 32;

    typedef logic [DIFT_TAG_WIDTH-1:0] dift_tag_t;

    typedef struct packed {
        logic                     valid;
        logic [RF_ADDR_WIDTH-1:0] waddr;
        logic [RF_DATA_WIDTH-1:0] wdata;
        dift_tag_t                tag;
    } rf_wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LSU,
        SRC_APU
    } wb_src_e;

endpackage

// File: rtl/riscv_rf_wb_fifo.sv
// ----------------------------------------------------------------------------
// riscv_rf_wb_fifo
//   Synchronous FIFO buffering APU results until a write port is free.
//   Pointers carry one extra wrap bit so full/empty are unambiguous.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_i            enqueue push_addr_i / push_pl_i
//   pop_i             dequeue the head entry
//   empty_o, full_o   occupancy flags
//   cnt_o             number of valid entries
//   head_addr_o/pl_o  oldest entry
//   entry_addr_o      address of every slot, slot i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   entry_valid_o     slot i currently holds a live entry
// ----------------------------------------------------------------------------
module riscv_rf_wb_fifo #(
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned ADDR_WIDTH    = 6,
    parameter int unsigned PAYLOAD_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  logic [ADDR_WIDTH-1:0]         push_addr_i,
    input  logic [PAYLOAD_WIDTH-1:0]      push_pl_i,
    input  logic                          pop_i,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [$clog2(DEPTH):0]        cnt_o,
    output logic [ADDR_WIDTH-1:0]         head_addr_o,
    output logic [PAYLOAD_WIDTH-1:0]      head_pl_o,
    output logic [DEPTH*ADDR_WIDTH-1:0]   entry_addr_o,
    output logic [DEPTH-1:0]              entry_valid_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]             rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0]      addr_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]      addr_mem_d [DEPTH];
    logic [PAYLOAD_WIDTH-1:0]   pl_mem_q   [DEPTH];
    logic [PAYLOAD_WIDTH-1:0]   pl_mem_d   [DEPTH];
    logic [PTR_W-1:0]           entry_off;

    assign cnt_o       = wr_ptr_q - rd_ptr_q;
    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                         (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_addr_o = addr_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign head_pl_o   = pl_mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        addr_mem_d = addr_mem_q;
        pl_mem_d   = pl_mem_q;
        // Push into a full FIFO is only legal together with a pop: the slot
        // being written is the one the head vacates.
        if (push_i) begin
            addr_mem_d[wr_ptr_q[PTR_W-1:0]] = push_addr_i;
            pl_mem_d[wr_ptr_q[PTR_W-1:0]]   = push_pl_i;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        entry_off     = '0;
        entry_valid_o = '0;
        entry_addr_o  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_off        = PTR_W'(i) - rd_ptr_q[PTR_W-1:0];
            entry_valid_o[i] = ({1'b0, entry_off} < cnt_o);
            entry_addr_o[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_mem_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_mem_q[i] <= '0;
                pl_mem_q[i]   <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            addr_mem_q <= addr_mem_d;
            pl_mem_q   <= pl_mem_d;
        end
    end

endmodule

// File: rtl/riscv_rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// riscv_rf_wb_arbiter
//   Merges ALU, LSU and (unsynchronised) APU results onto register-file write
//   ports A and B with registered outputs. APU results that miss a port are
//   buffered; pend_mask_o exposes buffered destinations so ID can stall
//   writers that would overtake them. A starvation counter eventually blocks
//   the ALU for one cycle so the buffered head can drain.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   alu_valid_i/alu_ready_o, alu_*   ALU write request (blocked on forced slot)
//   lsu_valid_i, lsu_*               LSU write request, always accepted
//   apu_valid_i/apu_ready_o, apu_*   APU write request (ready = FIFO not full)
//   *_wtag_i, wtag_*_o               DIFT tags (DIFT_ACTIVE builds only)
//   we/waddr/wdata_a_o, _b_o         register-file write ports
//   pend_mask_o                      one bit per address buffered in the FIFO
//   fifo_cnt_o                       FIFO occupancy
// ----------------------------------------------------------------------------
module riscv_rf_wb_arbiter
    import riscv_rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid_i,
    output logic                          alu_ready_o,
    input  logic [ADDR_WIDTH-1:0]         alu_waddr_i,
    input  logic [DATA_WIDTH-1:0]         alu_wdata_i,
    input  logic                          lsu_valid_i,
    input  logic [ADDR_WIDTH-1:0]         lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0]         lsu_wdata_i,
    input  logic                          apu_valid_i,
    output logic                          apu_ready_o,
    input  logic [ADDR_WIDTH-1:0]         apu_waddr_i,
    input  logic [DATA_WIDTH-1:0]         apu_wdata_i,
`ifdef DIFT_ACTIVE
    input  dift_tag_t                     alu_wtag_i,
    input  dift_tag_t                     lsu_wtag_i,
    input  dift_tag_t                     apu_wtag_i,
    output dift_tag_t                     wtag_a_o,
    output dift_tag_t                     wtag_b_o,
`endif
    output logic                          we_a_o,
    output logic [ADDR_WIDTH-1:0]         waddr_a_o,
    output logic [DATA_WIDTH-1:0]         wdata_a_o,
    output logic                          we_b_o,
    output logic [ADDR_WIDTH-1:0]         waddr_b_o,
    output logic [DATA_WIDTH-1:0]         wdata_b_o,
    output logic [2**ADDR_WIDTH-1:0]      pend_mask_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

`ifdef DIFT_ACTIVE
    localparam int unsigned TAG_W = $bits(dift_tag_t);
`else
    localparam int unsigned TAG_W = 0;
`endif
    // Payload = {tag, data}; the tag field is absent in non-DIFT builds.
    localparam int unsigned PW = DATA_WIDTH + TAG_W;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [PW-1:0] alu_pl, lsu_pl, apu_pl;
`ifdef DIFT_ACTIVE
    assign alu_pl = {alu_wtag_i, alu_wdata_i};
    assign lsu_pl = {lsu_wtag_i, lsu_wdata_i};
    assign apu_pl = {apu_wtag_i, apu_wdata_i};
`else
    assign alu_pl = alu_wdata_i;
    assign lsu_pl = lsu_wdata_i;
    assign apu_pl = apu_wdata_i;
`endif

    logic                           fifo_empty, fifo_full;
    logic [ADDR_WIDTH-1:0]          head_addr;
    logic [PW-1:0]                  head_pl;
    logic [FIFO_DEPTH*ADDR_WIDTH-1:0] entry_addr;
    logic [FIFO_DEPTH-1:0]          entry_valid;
    logic                           fifo_push, fifo_pop;

    logic [SW-1:0]                  starve_q, starve_d;
    logic                           force_slot;
    logic                           alu_fire, apu_fire;
    logic                           alu_w, lsu_w, apu_nz;
    logic                           cand_v, cand_taken, collide;
    logic [ADDR_WIDTH-1:0]          cand_addr, addr_a, addr_b;
    logic [PW-1:0]                  cand_pl, pl_a, pl_b;
    wb_src_e                        sel_a, sel_b;

    logic                           we_a_q, we_a_d, we_b_q, we_b_d;
    logic [ADDR_WIDTH-1:0]          waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
    logic [PW-1:0]                  wpl_a_q, wpl_a_d, wpl_b_q, wpl_b_d;

    riscv_rf_wb_fifo #(
        .DEPTH         (FIFO_DEPTH),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .PAYLOAD_WIDTH (PW)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push_i        (fifo_push),
        .push_addr_i   (apu_waddr_i),
        .push_pl_i     (apu_pl),
        .pop_i         (fifo_pop),
        .empty_o       (fifo_empty),
        .full_o        (fifo_full),
        .cnt_o         (fifo_cnt_o),
        .head_addr_o   (head_addr),
        .head_pl_o     (head_pl),
        .entry_addr_o  (entry_addr),
        .entry_valid_o (entry_valid)
    );

    // Ready comes from the pre-dequeue occupancy, so a full FIFO refuses
    // input even in a cycle where its head drains.
    assign apu_ready_o = !fifo_full;
    assign force_slot  = (starve_q == SW'(STARVE_LIMIT));
    assign alu_ready_o = !force_slot;

    assign alu_fire = alu_valid_i && alu_ready_o;
    assign apu_fire = apu_valid_i && apu_ready_o;

    // Integer x0 writes are accepted and dropped.
    assign alu_w  = alu_fire && (alu_waddr_i != '0);
    assign lsu_w  = lsu_valid_i && (lsu_waddr_i != '0);
    assign apu_nz = apu_waddr_i != '0;

    // APU candidate: buffered head if any, otherwise bypass of the input.
    assign cand_v    = !fifo_empty || (apu_fire && apu_nz);
    assign cand_addr = fifo_empty ? apu_waddr_i : head_addr;
    assign cand_pl   = fifo_empty ? apu_pl : head_pl;

    always_comb begin
        sel_a = SRC_NONE;
        sel_b = SRC_NONE;
        if (lsu_w) begin
            sel_b = SRC_LSU;
        end else if (cand_v) begin
            sel_b = SRC_APU;
        end
        if (alu_w) begin
            sel_a = SRC_ALU;
        end else if (cand_v && (sel_b == SRC_LSU)) begin
            sel_a = SRC_APU;
        end
    end

    always_comb begin
        addr_a = '0;
        pl_a   = '0;
        addr_b = '0;
        pl_b   = '0;
        case (sel_a)
            SRC_ALU: begin addr_a = alu_waddr_i; pl_a = alu_pl;  end
            SRC_APU: begin addr_a = cand_addr;   pl_a = cand_pl; end
            default: ;
        endcase
        case (sel_b)
            SRC_LSU: begin addr_b = lsu_waddr_i; pl_b = lsu_pl;  end
            SRC_APU: begin addr_b = cand_addr;   pl_b = cand_pl; end
            default: ;
        endcase
    end

    // Age order is candidate < LSU < ALU, so on an address clash the younger
    // write is the ALU when it owns port A, otherwise whatever owns port B.
    assign collide    = (sel_a != SRC_NONE) && (sel_b != SRC_NONE) && (addr_a == addr_b);
    assign cand_taken = (sel_a == SRC_APU) || (sel_b == SRC_APU);
    assign fifo_pop   = cand_taken && !fifo_empty;
    assign fifo_push  = apu_fire && apu_nz && !(fifo_empty && cand_taken);

    always_comb begin
        we_a_d    = (sel_a != SRC_NONE) && !collide;
        waddr_a_d = waddr_a_q;
        wpl_a_d   = wpl_a_q;
        if (we_a_d) begin
            waddr_a_d = addr_a;
            wpl_a_d   = pl_a;
        end

        we_b_d    = (sel_b != SRC_NONE);
        waddr_b_d = waddr_b_q;
        wpl_b_d   = wpl_b_q;
        if (collide && (sel_a == SRC_ALU)) begin
            waddr_b_d = addr_a;
            wpl_b_d   = pl_a;
        end else if (we_b_d) begin
            waddr_b_d = addr_b;
            wpl_b_d   = pl_b;
        end

        starve_d = starve_q;
        if (fifo_pop) begin
            starve_d = '0;
        end else if (!fifo_empty) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        pend_mask_o = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i]) begin
                pend_mask_o[entry_addr[i*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_a_q    <= 1'b0;
            waddr_a_q <= '0;
            wpl_a_q   <= '0;
            we_b_q    <= 1'b0;
            waddr_b_q <= '0;
            wpl_b_q   <= '0;
            starve_q  <= '0;
        end else begin
            we_a_q    <= we_a_d;
            waddr_a_q <= waddr_a_d;
            wpl_a_q   <= wpl_a_d;
            we_b_q    <= we_b_d;
            waddr_b_q <= waddr_b_d;
            wpl_b_q   <= wpl_b_d;
            starve_q  <= starve_d;
        end
    end

    assign we_a_o    = we_a_q;
    assign waddr_a_o = waddr_a_q;
    assign wdata_a_o = wpl_a_q[DATA_WIDTH-1:0];
    assign we_b_o    = we_b_q;
    assign waddr_b_o = waddr_b_q;
    assign wdata_b_o = wpl_b_q[DATA_WIDTH-1:0];
`ifdef DIFT_ACTIVE
    assign wtag_a_o  = wpl_a_q[PW-1:DATA_WIDTH];
    assign wtag_b_o  = wpl_b_q[PW-1:DATA_WIDTH];
`endif

endmodule

// File: tb/tb_riscv_rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_riscv_rf_wb_arbiter
//   Directed self-checking bench for riscv_rf_wb_arbiter with default
//   parameters (ADDR 6, DATA 32, FIFO depth 2, starvation limit 4).
// ----------------------------------------------------------------------------
module tb_riscv_rf_wb_arbiter;
    import riscv_rf_wb_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid_i = 1'b0, lsu_valid_i = 1'b0, apu_valid_i = 1'b0;
    logic [5:0]  alu_waddr_i = '0, lsu_waddr_i = '0, apu_waddr_i = '0;
    logic [31:0] alu_wdata_i = '0, lsu_wdata_i = '0, apu_wdata_i = '0;
    logic        alu_ready_o, apu_ready_o;
    logic        we_a_o, we_b_o;
    logic [5:0]  waddr_a_o, waddr_b_o;
    logic [31:0] wdata_a_o, wdata_b_o;
    logic [63:0] pend_mask_o;
    logic [1:0]  fifo_cnt_o;
`ifdef DIFT_ACTIVE
    dift_tag_t   alu_wtag_i = '0, lsu_wtag_i = '0, apu_wtag_i = '0;
    dift_tag_t   wtag_a_o, wtag_b_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_rf_wb_arbiter #(
        .ADDR_WIDTH   (6),
        .DATA_WIDTH   (32),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid_i (alu_valid_i),
        .alu_ready_o (alu_ready_o),
        .alu_waddr_i (alu_waddr_i),
        .alu_wdata_i (alu_wdata_i),
        .lsu_valid_i (lsu_valid_i),
        .lsu_waddr_i (lsu_waddr_i),
        .lsu_wdata_i (lsu_wdata_i),
        .apu_valid_i (apu_valid_i),
        .apu_ready_o (apu_ready_o),
        .apu_waddr_i (apu_waddr_i),
        .apu_wdata_i (apu_wdata_i),
`ifdef DIFT_ACTIVE
        .alu_wtag_i  (alu_wtag_i),
        .lsu_wtag_i  (lsu_wtag_i),
        .apu_wtag_i  (apu_wtag_i),
        .wtag_a_o    (wtag_a_o),
        .wtag_b_o    (wtag_b_o),
`endif
        .we_a_o      (we_a_o),
        .waddr_a_o   (waddr_a_o),
        .wdata_a_o   (wdata_a_o),
        .we_b_o      (we_b_o),
        .waddr_b_o   (waddr_b_o),
        .wdata_b_o   (wdata_b_o),
        .pend_mask_o (pend_mask_o),
        .fifo_cnt_o  (fifo_cnt_o)
    );

    task automatic drive(input logic av, input logic [5:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [5:0] la, input logic [31:0] ld,
                         input logic pv, input logic [5:0] pa, input logic [31:0] pd);
        alu_valid_i = av; alu_waddr_i = aa; alu_wdata_i = ad;
        lsu_valid_i = lv; lsu_waddr_i = la; lsu_wdata_i = ld;
        apu_valid_i = pv; apu_waddr_i = pa; apu_wdata_i = pd;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Advance past the next active edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        #1;
        checks++;
        if ({we_a_o, we_b_o, fifo_cnt_o, alu_ready_o, apu_ready_o} !== {1'b0, 1'b0, 2'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_ctrl got %b want %b", {we_a_o, we_b_o, fifo_cnt_o, alu_ready_o, apu_ready_o}, 6'b000011);
        end
        checks++;
        if ({waddr_a_o, wdata_a_o, waddr_b_o, wdata_b_o, pend_mask_o} !== '0) begin
            errors++;
            $display("FAIL reset_data got a=%h/%h b=%h/%h mask=%h want all zero",
                     waddr_a_o, wdata_a_o, waddr_b_o, wdata_b_o, pend_mask_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if ({we_a_o, we_b_o} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_we got %b want 00", {we_a_o, we_b_o});
        end
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        drive(1'b1, 6'd5, 32'h11, 1'b1, 6'd6, 32'h22, 1'b0, '0, '0);
        step();
        checks++;
        if ({we_a_o, waddr_a_o, wdata_a_o} !== {1'b1, 6'd5, 32'h11}) begin
            errors++;
            $display("FAIL dual_port_a got %b/%0d/%h want 1/5/00000011", we_a_o, waddr_a_o, wdata_a_o);
        end
        checks++;
        if ({we_b_o, waddr_b_o, wdata_b_o} !== {1'b1, 6'd6, 32'h22}) begin
            errors++;
            $display("FAIL dual_port_b got %b/%0d/%h want 1/6/00000022", we_b_o, waddr_b_o, wdata_b_o);
        end
        @(negedge clk);
        idle();
        step();
        checks++;
        if ({we_a_o, we_b_o} !== 2'b00) begin
            errors++;
            $display("FAIL dual_idle_we got %b want 00", {we_a_o, we_b_o});
        end
    endtask

    task automatic test_same_addr();
        @(negedge clk);
        drive(1'b1, 6'd7, 32'hA, 1'b1, 6'd7, 32'hB, 1'b0, '0, '0);
        step();
        checks++;
        if ({we_a_o, we_b_o, waddr_b_o, wdata_b_o} !== {1'b0, 1'b1, 6'd7, 32'hA}) begin
            errors++;
            $display("FAIL same_alu_lsu got a=%b b=%b/%0d/%h want a=0 b=1/7/0000000a",
                     we_a_o, we_b_o, waddr_b_o, wdata_b_o);
        end
        // APU bypass vs ALU on x12: ALU is younger, APU retires without buffering.
        @(negedge clk);
        drive(1'b1, 6'd12, 32'hD, 1'b0, '0, '0, 1'b1, 6'd12, 32'hC);
        step();
        checks++;
        if ({we_a_o, we_b_o, waddr_b_o, wdata_b_o, fifo_cnt_o} !== {1'b0, 1'b1, 6'd12, 32'hD, 2'd0}) begin
            errors++;
            $display("FAIL same_alu_apu got a=%b b=%b/%0d/%h cnt=%0d want a=0 b=1/12/0000000d cnt=0",
                     we_a_o, we_b_o, waddr_b_o, wdata_b_o, fifo_cnt_o);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_bypass();
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 6'd9, 32'h99);
        step();
        checks++;
        if ({we_a_o, we_b_o, waddr_b_o, wdata_b_o, fifo_cnt_o} !== {1'b0, 1'b1, 6'd9, 32'h99, 2'd0}) begin
            errors++;
            $display("FAIL bypass_b got a=%b b=%b/%0d/%h cnt=%0d want a=0 b=1/9/00000099 cnt=0",
                     we_a_o, we_b_o, waddr_b_o, wdata_b_o, fifo_cnt_o);
        end
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b1, 6'd3, 32'h3, 1'b1, 6'd4, 32'h4);
        step();
        checks++;
        if ({we_a_o, waddr_a_o, wdata_a_o, we_b_o, waddr_b_o, fifo_cnt_o} !==
            {1'b1, 6'd4, 32'h4, 1'b1, 6'd3, 2'd0}) begin
            errors++;
            $display("FAIL bypass_a got a=%b/%0d/%h b=%b/%0d cnt=%0d want a=1/4/00000004 b=1/3 cnt=0",
                     we_a_o, waddr_a_o, wdata_a_o, we_b_o, waddr_b_o, fifo_cnt_o);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_apu_buffer();
        @(negedge clk);
        drive(1'b1, 6'd1, 32'h1, 1'b1, 6'd2, 32'h2, 1'b1, 6'd35, 32'h33);
        step();
        checks++;
        if ({we_a_o, waddr_a_o, we_b_o, waddr_b_o, fifo_cnt_o, pend_mask_o[35]} !==
            {1'b1, 6'd1, 1'b1, 6'd2, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL buffer_enq got a=%b/%0d b=%b/%0d cnt=%0d m35=%b want a=1/1 b=1/2 cnt=1 m35=1",
                     we_a_o, waddr_a_o, we_b_o, waddr_b_o, fifo_cnt_o, pend_mask_o[35]);
        end
        @(negedge clk);
        idle();
        step();
        checks++;
        if ({we_a_o, we_b_o, waddr_b_o, wdata_b_o} !== {1'b0, 1'b1, 6'd35, 32'h33}) begin
            errors++;
            $display("FAIL buffer_drain got a=%b b=%b/%0d/%h want a=0 b=1/35/00000033",
                     we_a_o, we_b_o, waddr_b_o, wdata_b_o);
        end
        checks++;
        if ({fifo_cnt_o, pend_mask_o} !== {2'd0, 64'd0}) begin
            errors++;
            $display("FAIL buffer_clear got cnt=%0d mask=%h want cnt=0 mask=0", fifo_cnt_o, pend_mask_o);
        end
    endtask

    task automatic test_starvation();
        @(negedge clk);
        drive(1'b1, 6'd1, 32'h1, 1'b1, 6'd2, 32'h2, 1'b1, 6'd40, 32'h40);
        step();
        checks++;
        if (fifo_cnt_o !== 2'd1) begin
            errors++;
            $display("FAIL starve_setup_cnt got %0d want 1", fifo_cnt_o);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b1, 6'd10, 32'h100, 1'b1, 6'd11, 32'h200, 1'b0, '0, '0);
            #1;
            checks++;
            if (alu_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL starve_ready_%0d got %b want 1", k, alu_ready_o);
            end
            step();
            checks++;
            if ({we_a_o, waddr_a_o, fifo_cnt_o} !== {1'b1, 6'd10, 2'd1}) begin
                errors++;
                $display("FAIL starve_blocked_%0d got a=%b/%0d cnt=%0d want a=1/10 cnt=1",
                         k, we_a_o, waddr_a_o, fifo_cnt_o);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (alu_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL starve_force_ready got %b want 0", alu_ready_o);
        end
        step();
        checks++;
        if ({we_a_o, waddr_a_o, wdata_a_o, we_b_o, waddr_b_o, fifo_cnt_o} !==
            {1'b1, 6'd40, 32'h40, 1'b1, 6'd11, 2'd0}) begin
            errors++;
            $display("FAIL starve_force_issue got a=%b/%0d/%h b=%b/%0d cnt=%0d want a=1/40/00000040 b=1/11 cnt=0",
                     we_a_o, waddr_a_o, wdata_a_o, we_b_o, waddr_b_o, fifo_cnt_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (alu_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL starve_after_ready got %b want 1", alu_ready_o);
        end
        step();
        checks++;
        if ({we_a_o, waddr_a_o} !== {1'b1, 6'd10}) begin
            errors++;
            $display("FAIL starve_after_alu got a=%b/%0d want a=1/10", we_a_o, waddr_a_o);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_full_and_reset();
        @(negedge clk);
        drive(1'b1, 6'd10, 32'h1, 1'b1, 6'd11, 32'h2, 1'b1, 6'd33, 32'h33);
        step();
        @(negedge clk);
        drive(1'b1, 6'd10, 32'h1, 1'b1, 6'd11, 32'h2, 1'b1, 6'd34, 32'h34);
        step();
        checks++;
        if (fifo_cnt_o !== 2'd2) begin
            errors++;
            $display("FAIL full_cnt got %0d want 2", fifo_cnt_o);
        end
        @(negedge clk);
        drive(1'b1, 6'd10, 32'h1, 1'b1, 6'd11, 32'h2, 1'b1, 6'd36, 32'h36);
        #1;
        checks++;
        if (apu_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_ready got %b want 0", apu_ready_o);
        end
        step();
        checks++;
        if ({fifo_cnt_o, pend_mask_o[33], pend_mask_o[34], pend_mask_o[36]} !== {2'd2, 3'b110}) begin
            errors++;
            $display("FAIL full_hold got cnt=%0d m33/34/36=%b%b%b want cnt=2 m=110",
                     fifo_cnt_o, pend_mask_o[33], pend_mask_o[34], pend_mask_o[36]);
        end
        // Ports free, x36 still offered: head drains but full FIFO keeps refusing.
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 6'd36, 32'h36);
        #1;
        checks++;
        if (apu_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_drain_ready got %b want 0", apu_ready_o);
        end
        step();
        checks++;
        if ({we_b_o, waddr_b_o, wdata_b_o, fifo_cnt_o} !== {1'b1, 6'd33, 32'h33, 2'd1}) begin
            errors++;
            $display("FAIL full_drain0 got b=%b/%0d/%h cnt=%0d want b=1/33/00000033 cnt=1",
                     we_b_o, waddr_b_o, wdata_b_o, fifo_cnt_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (apu_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full_reopen_ready got %b want 1", apu_ready_o);
        end
        step();
        checks++;
        if ({we_b_o, waddr_b_o, wdata_b_o, fifo_cnt_o, pend_mask_o[36]} !== {1'b1, 6'd34, 32'h34, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL full_drain1 got b=%b/%0d/%h cnt=%0d m36=%b want b=1/34/00000034 cnt=1 m36=1",
                     we_b_o, waddr_b_o, wdata_b_o, fifo_cnt_o, pend_mask_o[36]);
        end
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({we_a_o, we_b_o, fifo_cnt_o, pend_mask_o, apu_ready_o} !== {1'b0, 1'b0, 2'd0, 64'd0, 1'b1}) begin
            errors++;
            $display("FAIL midreset got we=%b%b cnt=%0d mask=%h ardy=%b want we=00 cnt=0 mask=0 ardy=1",
                     we_a_o, we_b_o, fifo_cnt_o, pend_mask_o, apu_ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if ({we_a_o, we_b_o, fifo_cnt_o} !== {1'b0, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL midreset_release got we=%b%b cnt=%0d want we=00 cnt=0", we_a_o, we_b_o, fifo_cnt_o);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        drive(1'b1, 6'd0, 32'hDEAD, 1'b1, 6'd0, 32'hBEEF, 1'b1, 6'd0, 32'hCAFE);
        #1;
        checks++;
        if ({alu_ready_o, apu_ready_o} !== 2'b11) begin
            errors++;
            $display("FAIL x0_ready got %b want 11", {alu_ready_o, apu_ready_o});
        end
        step();
        checks++;
        if ({we_a_o, we_b_o, fifo_cnt_o, pend_mask_o[0]} !== {1'b0, 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL x0_discard got we=%b%b cnt=%0d m0=%b want we=00 cnt=0 m0=0",
                     we_a_o, we_b_o, fifo_cnt_o, pend_mask_o[0]);
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_same_addr();
        test_bypass();
        test_apu_buffer();
        test_starvation();
        test_full_and_reset();
        test_x0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_rf_wb_arbiter.md
# riscv_rf_wb_arbiter

Write-back arbiter and scheduler for the two write ports of the integer/FP register file. It merges three result sources onto write ports A and B with registered outputs: ALU/EX results, LSU load data, and APU/FPU results that arrive unsynchronised. APU results are buffered in a small FIFO until a port is free. A pending-address mask lets the ID stage stall writers that would overtake a buffered APU result. The block sits between the EX/LSU/APU result buses and the register file write ports.

## Interface
- ADDR_WIDTH, 6: register address width; bit 5 selects the FP bank.
- DATA_WIDTH, 32: data width.
- FIFO_DEPTH, 2: APU result buffer entries, power of two, at least 2.
- STARVE_LIMIT, 4: number of cycles a FIFO head may wait before a port is forced free.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alu_valid_i / alu_ready_o  in/out  1  ALU write request/accept
- alu_waddr_i, alu_wdata_i  in  ADDR_WIDTH, DATA_WIDTH  ALU write address and data
- lsu_valid_i  in  1  LSU write request, always accepted
- lsu_waddr_i, lsu_wdata_i  in  ADDR_WIDTH, DATA_WIDTH  LSU write address and data
- apu_valid_i / apu_ready_o  in/out  1  APU write request/accept; ready = FIFO not full
- apu_waddr_i, apu_wdata_i  in  ADDR_WIDTH, DATA_WIDTH  APU write address and data
- alu_wtag_i, lsu_wtag_i, apu_wtag_i  in  dift_tag_t  DIFT tags; present only under DIFT_ACTIVE
- we_a_o, waddr_a_o, wdata_a_o  out  1, ADDR_WIDTH, DATA_WIDTH  register file port A
- we_b_o, waddr_b_o, wdata_b_o  out  1, ADDR_WIDTH, DATA_WIDTH  register file port B
- wtag_a_o, wtag_b_o  out  dift_tag_t  tags for ports A and B; present only under DIFT_ACTIVE
- pend_mask_o  out  2**ADDR_WIDTH  bit set for each address held in the FIFO
- fifo_cnt_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- Handshake: a transfer occurs on valid && ready. alu_ready_o = !force_slot. LSU has no ready signal.
- Address 0 (integer x0): the request is accepted and discarded; no port is used and nothing is enqueued.
- Age order, oldest first: FIFO head, APU input, LSU, ALU. Each ID-issued writer is younger than any buffered APU result.
- Per-cycle port selection:
  - B = LSU if valid; else the APU candidate.
  - A = ALU if accepted; else the APU candidate, if B is taken.
  - The APU candidate is the FIFO head if the FIFO is non-empty; else the APU input (bypass).
- Same-address rule: if both selected writes target the same address, only the younger one is issued, on port B. The older write is retired as overwritten and frees its source (it is dequeued or accepted).
- APU input that does not get a port is enqueued when ready. Simultaneous dequeue and enqueue on a full FIFO is allowed; apu_ready_o is computed on pre-dequeue count, so it stays 0.
- Starvation: a counter increments each cycle the FIFO is non-empty and its head is not issued, and resets on dequeue. When count == STARVE_LIMIT, force_slot=1 for one cycle: alu_ready_o=0 and the head takes port A.
- pend_mask_o is the OR of decoded valid FIFO entry addresses. ID must not issue an instruction whose destination is set in this mask.

## Timing
- Outputs are registered: one cycle from accepted request to we_*_o.
- The FIFO head becomes visible the cycle after enqueue. Bypass latency is 1 cycle; buffered latency is at least 2 cycles.
- Reset values: we_a_o=we_b_o=0, addresses/data/tags=0, fifo_cnt_o=0, pend_mask_o=0, apu_ready_o=1, alu_ready_o=1, starvation counter=0.
- Asynchronous reset mid-operation discards the FIFO contents and the in-flight output registers. No write is issued in the first cycle after reset release.
- Wrap-around: the FIFO pointers use ADDR of $clog2(FIFO_DEPTH) bits plus a wrap bit. full = pointers equal and wrap bits differ.

## Structure
- dift_tag_t comes from the shared DIFT configuration. Put an rf_wb_req_t struct (valid, waddr, wdata, tag) in riscv_defines so EX/LSU/APU can share it.
- One sub-module: riscv_rf_wb_fifo (synchronous FIFO with count and per-entry address taps for the mask).
- Top-level: selection logic, starvation counter, output registers.

## Test plan
- ALU x5=0x11 and LSU x6=0x22 in the same cycle -> next cycle we_a_o=1 waddr_a_o=5 and we_b_o=1 waddr_b_o=6; both data values correct.
- ALU and LSU both target x7 (0xA, 0xB) -> only port B writes x7=0xA (the ALU value); we_a_o=0.
- APU f3 result arrives while ALU and LSU are both valid -> enqueued, fifo_cnt_o=1, pend_mask_o[35]=1. The next idle cycle drains it on B and the mask clears.
- ALU valid continuously with the FIFO holding 1 entry, STARVE_LIMIT=4 -> after 4 blocked cycles alu_ready_o=0 for exactly one cycle and the head issues on A.
- FIFO full (2 entries) plus apu_valid_i -> apu_ready_o=0, no entry lost. Assert rst_n mid-stream -> all we_*_o=0 and fifo_cnt_o=0 immediately.
- A write to x0 from each source -> no port enable, and the requester is accepted.
